load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle load/store stage of the RISC-V core.
- Accepts one memory instruction at a time from execute and runs a req/gnt/rvalid handshake with the data memory.
- Aligns and sign- or zero-extends load data.
- Drives the register_file write port (en, register_file_data, rd) for exactly one cycle per completed load.
- Stores complete without a register write.

Parameters:
- ADDR_WIDTH, 32, width of byte address and mem_addr.
- DATA_WIDTH, 32, data width; fixed at 32 (RV32I). Other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lsu_valid  input  1  execute presents a memory instruction.
- lsu_ready  output  1  unit can accept; handshake occurs when lsu_valid && lsu_ready.
- is_load  input  1  1 = load, 0 = store.
- funct3  input  3  RV32I width/sign code.
- address  input  ADDR_WIDTH  effective byte address.
- store_data  input  32  rs2 value for stores.
- rd_in  input  5  load destination register.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write.
- mem_be  output  4  byte enables.
- mem_addr  output  ADDR_WIDTH  word-aligned address ({address[31:2],2'b00}).
- mem_wdata  output  32  lane-replicated store data.
- mem_gnt  input  1  memory accepted request this cycle.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  32  read word.
- en  output  1  register file write enable.
- register_file_data  output  32  write-back data.
- rd  output  5  write-back register address.
- lsu_error  output  1  one-cycle pulse on misaligned access or illegal funct3.

Behaviour:
- Reset (async, any state): state=IDLE; lsu_ready=1; mem_req, mem_we, en, lsu_error = 0; mem_be=0; mem_addr, mem_wdata, register_file_data = 0; rd=0. Takes effect immediately, including mid-transaction; mem_req drops without waiting for gnt.
- FSM states: IDLE, REQ, WAIT, WB. All outputs are registered or decoded from registered state/capture registers only.
- IDLE: lsu_ready=1. On handshake, capture is_load, funct3, address[1:0], store_data, and rd_in.
  - Illegal funct3 (load: 011, 110, 111; store: anything other than 000, 001, 010) -> lsu_error=1 next cycle, stay IDLE, no memory access.
  - Misaligned access (halfword with addr[0]=1; word with addr[1:0]!=0) -> same as illegal funct3.
  - Otherwise -> REQ.
- REQ: mem_req=1, lsu_ready=0. mem_we, mem_be, mem_addr, mem_wdata are stable until mem_gnt.
  - On gnt: store -> IDLE; load -> WAIT.
- WAIT: mem_req=0. On mem_rvalid, form the write-back value from mem_rdata and go to WB. rvalid in the same cycle as gnt is not possible; memory returns rvalid at least one cycle after gnt.
- WB: en=1 for exactly one cycle with register_file_data and rd, then IDLE. If rd==0, en=0 but the transition is unchanged.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW: 4'b1111.
  - Loads: 4'b1111.
- Store data: SB replicates the byte into all 4 lanes; SH replicates the halfword into both lanes; SW passes the word through.
- Load extraction: byte lane = addr[1:0], halfword lane = addr[1].
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW: pass-through.
- mem_rvalid or mem_gnt outside WAIT or REQ respectively is ignored.
- Latency with gnt in the first REQ cycle and rvalid one cycle later: handshake at cycle 0, REQ at 1, WAIT at 2 (rvalid), en at 3.
- Store with immediate gnt: lsu_ready returns at cycle 2.

Test Plan:
- SW: address=0x100, store_data=0xDEADBEEF, gnt immediate -> one mem_req cycle with mem_we=1, mem_be=1111, mem_addr=0x100, mem_wdata=0xDEADBEEF; en never asserted.
- SB: address=0x103, store_data=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB/LBU: address=0x102, rd_in=7, mem_rdata=0x12F03456 -> LB writes register_file_data=0xFFFFFFF0, rd=7, en high exactly 1 cycle; LBU writes 0x000000F0.
- LH: address=0x106, rdata=0x80011234, gnt held low 3 cycles -> mem_req high 4 cycles with stable outputs; result=0xFFFF8001.
- LW: address=0x101 -> lsu_error pulse 1 cycle, mem_req stays 0, lsu_ready stays 1; repeat with funct3=3'b111 on a load -> same response.
- Reset in WAIT: assert rst, then pulse mem_rvalid after release -> no en pulse, state IDLE, lsu_ready=1; a load with rd_in=0 completes with en=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store stage: accepts one memory instruction from execute, runs the
// req/gnt/rvalid handshake with data memory and writes aligned load data back.
module load_store_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lsu_valid,
   output logic                  lsu_ready,
   input  logic                  is_load,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [4:0]            rd_in,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [3:0]            mem_be,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  en,
   output logic [DATA_WIDTH-1:0] register_file_data,
   output logic [4:0]            rd,
   output logic                  lsu_error
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

   state_t                state, next_state;
   logic                  is_load_q;
   logic [2:0]            funct3_q;
   logic [1:0]            addr_low_q;
   logic [3:0]            be_q;
   logic [4:0]            rd_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  error_q;

   logic                  handshake, illegal, misaligned, reject;
   logic [3:0]            be_next;
   logic [DATA_WIDTH-1:0] wdata_next;
   logic [DATA_WIDTH-1:0] load_value;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;

   // Decode the incoming instruction; funct3[1:0] encodes the access size.
   always_comb begin
      handshake  = lsu_valid && (state == IDLE);
      if (is_load)
         illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      else
         illegal = (funct3 != 3'b000) && (funct3 != 3'b001) && (funct3 != 3'b010);
      misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                   ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
      reject     = illegal || misaligned;
      be_next    = 4'b1111;
      wdata_next = store_data;
      if (!is_load) begin
         case (funct3[1:0])
            2'b00: begin
               be_next    = 4'b0001 << address[1:0];
               wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
               be_next    = 4'b0011 << {address[1], 1'b0};
               wdata_next = {2{store_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      byte_sel = mem_rdata[{addr_low_q, 3'b000} +: 8];
      half_sel = addr_low_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_value = {24'b0, byte_sel};
         3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_value = {16'b0, half_sel};
         default: load_value = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (handshake && !reject) next_state = REQ;
         REQ:  if (mem_gnt) next_state = is_load_q ? WAIT : IDLE;
         WAIT: if (mem_rvalid) next_state = WB;
         WB:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture registers; request fields stay frozen from handshake until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_load_q  <= 1'b0;
         funct3_q   <= 3'b0;
         addr_low_q <= 2'b0;
         be_q       <= 4'b0;
         rd_q       <= 5'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         result_q   <= '0;
         error_q    <= 1'b0;
      end else begin
         error_q <= handshake && reject;
         if (handshake) begin
            is_load_q  <= is_load;
            funct3_q   <= funct3;
            addr_low_q <= address[1:0];
            be_q       <= be_next;
            rd_q       <= rd_in;
            addr_q     <= {address[ADDR_WIDTH-1:2], 2'b00};
            wdata_q    <= wdata_next;
         end
         if (state == WAIT && mem_rvalid)
            result_q <= load_value;
      end
   end

   assign lsu_ready          = (state == IDLE);
   assign mem_req            = (state == REQ);
   assign mem_we             = mem_req && !is_load_q;
   assign mem_be             = mem_req ? be_q : 4'b0000;
   assign mem_addr           = addr_q;
   assign mem_wdata          = wdata_q;
   assign en                 = (state == WB) && (rd_q != 5'd0);
   assign register_file_data = result_q;
   assign rd                 = rd_q;
   assign lsu_error          = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: memory requests and write-backs are
// queued when stimulus is driven and checked as the DUT produces them.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        lsu_valid;
   logic        lsu_ready;
   logic        is_load;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] store_data;
   logic [4:0]  rd_in;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        en;
   logic [31:0] register_file_data;
   logic [4:0]  rd;
   logic        lsu_error;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } reqExp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wbExp_t;

   reqExp_t reqQueue[$];
   wbExp_t  wbQueue[$];

   int checkCount = 0;
   int passCount  = 0;
   int enCycles   = 0;
   int reqCycles  = 0;
   int errCycles  = 0;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
      .is_load(is_load), .funct3(funct3), .address(address),
      .store_data(store_data), .rd_in(rd_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .en(en), .register_file_data(register_file_data), .rd(rd),
      .lsu_error(lsu_error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      else
         passCount++;
   endtask

   // Monitor at the falling edge: match requests and write-backs against the queues.
   task automatic sampleOutputs();
      reqExp_t r;
      wbExp_t  w;
      if (rst) return;
      if (lsu_error) errCycles++;
      if (en) begin
         enCycles++;
         if (wbQueue.size() == 0)
            checkOutput("unexpected_en", 32'd1, 32'd0);
         else begin
            w = wbQueue.pop_front();
            checkOutput("wb_rd", 32'(rd), 32'(w.rd));
            checkOutput("wb_data", register_file_data, w.data);
         end
      end
      if (mem_req) begin
         reqCycles++;
         if (reqQueue.size() == 0)
            checkOutput("unexpected_req", 32'd1, 32'd0);
         else begin
            r = reqQueue[0];
            checkOutput("req_we", 32'(mem_we), 32'(r.we));
            checkOutput("req_be", 32'(mem_be), 32'(r.be));
            checkOutput("req_addr", mem_addr, r.addr);
            if (r.we) checkOutput("req_wdata", mem_wdata, r.wdata);
            if (mem_gnt) void'(reqQueue.pop_front());
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      sampleOutputs();
      @(posedge clk);
      #1;
   endtask

   // One legal transaction; expected request fields and result come in as constants.
   task automatic applyStimulus(input logic isLoad, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [4:0] rdIn, input logic [31:0] rdata,
                                input int gntDelay, input logic [3:0] expBe, input logic [31:0] expWdata,
                                input logic [31:0] expResult);
      reqExp_t r;
      wbExp_t  w;
      int      req0, en0;
      req0 = reqCycles;
      en0  = enCycles;
      r.we = !isLoad; r.be = expBe; r.addr = {addr[31:2], 2'b00}; r.wdata = expWdata;
      reqQueue.push_back(r);
      if (isLoad && rdIn != 5'd0) begin
         w.rd = rdIn; w.data = expResult;
         wbQueue.push_back(w);
      end
      lsu_valid = 1'b1; is_load = isLoad; funct3 = f3; address = addr;
      store_data = sdata; rd_in = rdIn;
      step();
      lsu_valid = 1'b0;
      store_data = $urandom;
      repeat (gntDelay) step();
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      if (!isLoad)
         checkOutput("store_ready_cycle2", 32'(lsu_ready), 32'd1);
      else begin
         mem_rvalid = 1'b1;
         mem_rdata  = rdata;
         step();
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         checkOutput("wb_en_cycle3", 32'(en), 32'(rdIn != 5'd0));
         step();
      end
      step();
      checkOutput("req_cycle_count", 32'(reqCycles - req0), 32'(gntDelay + 1));
      checkOutput("en_cycle_count", 32'(enCycles - en0), 32'(isLoad && rdIn != 5'd0));
      checkOutput("ready_after_txn", 32'(lsu_ready), 32'd1);
   endtask

   task automatic applyError(input logic isLoad, input logic [2:0] f3, input logic [31:0] addr);
      int req0, err0;
      req0 = reqCycles;
      err0 = errCycles;
      lsu_valid = 1'b1; is_load = isLoad; funct3 = f3; address = addr; rd_in = 5'd9;
      step();
      lsu_valid = 1'b0;
      checkOutput("err_pulse", 32'(lsu_error), 32'd1);
      checkOutput("err_ready", 32'(lsu_ready), 32'd1);
      checkOutput("err_no_req", 32'(mem_req), 32'd0);
      step();
      checkOutput("err_cleared", 32'(lsu_error), 32'd0);
      step();
      checkOutput("err_cycle_count", 32'(errCycles - err0), 32'd1);
      checkOutput("err_req_count", 32'(reqCycles - req0), 32'd0);
   endtask

   initial begin
      reqExp_t r;
      int      en0;
      clk = 1'b0; rst = 1'b1;
      lsu_valid = 1'b0; is_load = 1'b0; funct3 = 3'b0; address = 32'h0;
      store_data = 32'h0; rd_in = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_ready", 32'(lsu_ready), 32'd1);
      checkOutput("rst_req", 32'(mem_req), 32'd0);
      checkOutput("rst_we", 32'(mem_we), 32'd0);
      checkOutput("rst_be", 32'(mem_be), 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'd0);
      checkOutput("rst_en", 32'(en), 32'd0);
      checkOutput("rst_wb_data", register_file_data, 32'd0);
      checkOutput("rst_rd", 32'(rd), 32'd0);
      checkOutput("rst_error", 32'(lsu_error), 32'd0);
      rst = 1'b0;
      step();

      // Stores: SW, SB, SH
      applyStimulus(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3, 32'h0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
      applyStimulus(1'b0, 3'b000, 32'h103, 32'h000000A5, 5'd3, 32'h0, 0, 4'b1000, 32'hA5A5A5A5, 32'h0);
      applyStimulus(1'b0, 3'b001, 32'h102, 32'h1234ABCD, 5'd3, 32'h0, 1, 4'b1100, 32'hABCDABCD, 32'h0);

      // Loads: LB, LBU, LH with stalled grant, LHU, LW
      applyStimulus(1'b1, 3'b000, 32'h102, 32'h0, 5'd7, 32'h12F03456, 0, 4'b1111, 32'h0, 32'hFFFFFFF0);
      applyStimulus(1'b1, 3'b100, 32'h102, 32'h0, 5'd7, 32'h12F03456, 0, 4'b1111, 32'h0, 32'h000000F0);
      applyStimulus(1'b1, 3'b001, 32'h106, 32'h0, 5'd12, 32'h80011234, 3, 4'b1111, 32'h0, 32'hFFFF8001);
      applyStimulus(1'b1, 3'b101, 32'h100, 32'h0, 5'd13, 32'h80011234, 0, 4'b1111, 32'h0, 32'h00001234);
      applyStimulus(1'b1, 3'b010, 32'h104, 32'h0, 5'd31, 32'hCAFEF00D, 2, 4'b1111, 32'h0, 32'hCAFEF00D);

      // Misaligned and illegal encodings
      applyError(1'b1, 3'b010, 32'h101);
      applyError(1'b1, 3'b111, 32'h100);
      applyError(1'b0, 3'b011, 32'h100);
      applyError(1'b0, 3'b001, 32'h103);

      // Reset while waiting for read data: the late rvalid must be ignored
      en0 = enCycles;
      r.we = 1'b0; r.be = 4'b1111; r.addr = 32'h200; r.wdata = 32'h0;
      reqQueue.push_back(r);
      lsu_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; address = 32'h200; rd_in = 5'd5;
      step();
      lsu_valid = 1'b0;
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rst_wait_ready", 32'(lsu_ready), 32'd1);
      checkOutput("rst_wait_en", 32'(en), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
      step();
      mem_rvalid = 1'b0;
      step();
      checkOutput("rst_wait_no_en", 32'(enCycles - en0), 32'd0);
      checkOutput("rst_wait_idle", 32'(lsu_ready), 32'd1);

      // Reset while requesting: mem_req drops without a grant
      lsu_valid = 1'b1; is_load = 1'b0; funct3 = 3'b010; address = 32'h300; store_data = 32'h1;
      step();
      lsu_valid = 1'b0;
      checkOutput("req_before_rst", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rst_req_drop", 32'(mem_req), 32'd0);
      checkOutput("rst_req_be", 32'(mem_be), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // Load to x0 finishes with no register write, then a normal load follows
      applyStimulus(1'b1, 3'b010, 32'h108, 32'h0, 5'd0, 32'h0BADF00D, 0, 4'b1111, 32'h0, 32'h0);
      applyStimulus(1'b1, 3'b000, 32'h10C, 32'h0, 5'd1, 32'h0000007F, 0, 4'b1111, 32'h0, 32'h0000007F);

      checkOutput("req_queue_drained", 32'(reqQueue.size()), 32'd0);
      checkOutput("wb_queue_drained", 32'(wbQueue.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
